// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub, plus a read-only view of the controller state.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    import serial_addsub_pkg::*;

    // start is a one-cycle request, accepted only when the block is IDLE or DONE;
    // done is a one-cycle pulse with S/Co/Ov valid; busy marks the RUN phase.
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             Ov;
    sa_state_t        dbg_state;

    modport master (
        output start, sub, A, B,
        input  busy, done, S, Co, Ov, dbg_state
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, S, Co, Ov, dbg_state
    );

endinterface

// File: rtl/serial_addsub_fa.sv
// One-bit full adder cell; the only arithmetic element in the serial datapath.
module serial_addsub_fa (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract: one full adder, LSB first, one bit per clock.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_addsub_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    sa_state_t        r_state;
    sa_state_t        w_next;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_cin_msb;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_co;
    logic             r_ov;

    logic             w_fa_s;
    logic             w_fa_co;
    logic [WIDTH-1:0] w_res_next;

    serial_addsub_fa u_fa (
        .A  (r_opa[0]),
        .B  (r_opb[0]),
        .Ci (r_carry),
        .S  (w_fa_s),
        .Co (w_fa_co)
    );

    assign w_res_next = {w_fa_s, r_res[WIDTH-1:1]};

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = (r_cnt == CNT_W'(WIDTH - 1));
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Subtraction is A + ~B + 1: invert B on load and seed the carry with sub.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa     <= '0;
            r_opb     <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_opa   <= bus.A;
            r_opb   <= bus.sub ? ~bus.B : bus.B;
            r_carry <= bus.sub;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
            r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
            r_res   <= w_res_next;
            r_carry <= w_fa_co;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cin_msb <= r_carry;
            end
        end
    end

    // Results update only on the final bit, so the previous answer stays visible during RUN.
    // Overflow is carry-into-MSB xor carry-out-of-MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s  <= '0;
            r_co <= 1'b0;
            r_ov <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_s  <= w_res_next;
            r_co <= w_fa_co;
            r_ov <= r_carry ^ w_fa_co;
        end
    end

    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.S         = r_s;
    assign bus.Co        = r_co;
    assign bus.Ov        = r_ov;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH=8.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected results packed as {S, Co, Ov}.
    logic [W+1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_s;
        logic         exp_co;
        logic         exp_ov;
        bit           now;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, subtraction as a + (2^W - b).
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
        int unsigned full;
        int          sa;
        int          sb;
        int          r;
        logic        ov;
        full = int'(a) + (s ? ((1 << W) - int'(b)) : int'(b));
        sa   = (a >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
        sb   = (b >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
        r    = s ? sa - sb : sa + sb;
        ov   = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        return {W'(full % (1 << W)), 1'((full >> W) & 1), ov};
    endfunction

    // Drives a start; with now=1 the start goes out in the current (DONE) cycle.
    // Returns at the negedge after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [W+1:0] exp, input bit now);
        if (!now) @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.sub   = s;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.sub   = 1'($urandom);
        check("accept_done_low", {31'd0, bus.done}, 32'd0);
    endtask

    // Counts busy cycles from the current negedge until done, then scores the result.
    task automatic finish_op(input bit b2b, input int pre);
        int          bc;
        bit          seen;
        logic [W+1:0] e;
        bc   = pre;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) bc++;
            @(negedge clk);
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("busy_cycles", bc, 32'd8);
        check("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
        if (exp_q.size() == 0) begin
            check("queue_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("result_S", {24'd0, bus.S}, {24'd0, e[W+1:2]});
            check("result_Co", {31'd0, bus.Co}, {31'd0, e[1]});
            check("result_Ov", {31'd0, bus.Ov}, {31'd0, e[0]});
        end
        if (!b2b) begin
            @(negedge clk);
            check("done_one_cycle", {31'd0, bus.done}, 32'd0);
            check("idle_after_done", {30'd0, bus.dbg_state}, {30'd0, IDLE});
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int dn;
        dn = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        check(name, dn, 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        bit           nb;
        int           pre;

        vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h5A, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst_n     = 1'b0;

        #3;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_S", {24'd0, bus.S}, 32'd0);
        check("reset_Co", {31'd0, bus.Co}, 32'd0);
        check("reset_Ov", {31'd0, bus.Ov}, 32'd0);
        check("reset_state", {30'd0, bus.dbg_state}, {30'd0, IDLE});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table; entry 4 is issued in the DONE cycle of entry 3.
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].sub,
                  {vecs[i].exp_s, vecs[i].exp_co, vecs[i].exp_ov}, vecs[i].now);
            if (vecs[i].now) check("b2b_busy", {31'd0, bus.busy}, 32'd1);
            finish_op((i < 6) && vecs[i + 1].now, 0);
        end

        // A second start during RUN must be dropped.
        issue(8'hF0, 8'h20, 1'b0, {8'h10, 1'b1, 1'b0}, 1'b0);
        pre = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.busy) pre++;
            if (k == 2) begin
                bus.start = 1'b1;
                bus.A     = 8'h11;
                bus.B     = 8'h11;
                bus.sub   = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        finish_op(1'b0, pre);
        expect_quiet("no_second_done", 12);
        check("queue_empty_after_ignore", exp_q.size(), 32'd0);

        // Reset in the middle of an operation.
        issue(8'h33, 8'h44, 1'b0, {8'h77, 1'b0, 1'b0}, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_S", {24'd0, bus.S}, 32'd0);
        check("midrst_Co", {31'd0, bus.Co}, 32'd0);
        check("midrst_Ov", {31'd0, bus.Ov}, 32'd0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_quiet("no_done_after_reset", 12);
        issue(8'h0A, 8'h05, 1'b0, {8'h0F, 1'b0, 1'b0}, 1'b0);
        finish_op(1'b0, 0);

        // Random operations, some back-to-back, scored against the integer model.
        nb = 1'b0;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            rs = 1'($urandom);
            issue(ra, rb, rs, model(ra, rb, rs), nb);
            nb = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            finish_op(nb, 0);
        end

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
